// File: rtl/sha256_pkg.sv
// Shared constants, round functions and state encodings for the UART SHA-256 block.
package sha256_pkg;

    typedef enum logic [1:0] {RX_WAIT, COMPUTE, TX_SEND} state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_HOLD} rx_state_t;

    localparam logic [0:7][31:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_core.sv
// Iterative SHA-256 compression of a single block from the IV: one round per clock,
// then one cycle for the final addition.
module sha256_core
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [511:0] block,
    output logic         done,
    output logic [255:0] digest
);

    logic [0:7][31:0]  wv;
    logic [0:15][31:0] w;
    logic [0:7][31:0]  hv;
    logic [5:0]        rnd;
    logic              busy;
    logic              fin;
    logic [31:0]       t1;
    logic [31:0]       t2;
    logic [31:0]       w_next;

    assign digest = hv;

    // w[0] is always W[t]; w_next is W[t+16], so the window rolls one word per round.
    always_comb begin
        t1     = wv[7] + big_sigma1(wv[4]) + ch(wv[4], wv[5], wv[6]) + K[rnd] + w[0];
        t2     = big_sigma0(wv[0]) + maj(wv[0], wv[1], wv[2]);
        w_next = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            fin  <= 1'b0;
            done <= 1'b0;
            rnd  <= '0;
            wv   <= '0;
            w    <= '0;
            hv   <= '0;
        end else begin
            done <= 1'b0;
            if (busy) begin
                wv  <= {t1 + t2, wv[0:2], wv[3] + t1, wv[4:6]};
                w   <= {w[1:15], w_next};
                rnd <= rnd + 6'd1;
                if (rnd == 6'd63) begin
                    busy <= 1'b0;
                    fin  <= 1'b1;
                end
            end else if (fin) begin
                fin  <= 1'b0;
                done <= 1'b1;
                for (int i = 0; i < 8; i++) hv[i] <= IV[i] + wv[i];
            end else if (start) begin
                busy <= 1'b1;
                rnd  <= '0;
                wv   <= IV;
                w    <= block;
            end
        end
    end

endmodule

// File: rtl/sha256_top.sv
// UART-attached SHA-256: 64 bytes in on data_in, 32 digest bytes back on data_out.
//   state   | meaning
//   RX_WAIT | collecting message bytes 0..63
//   COMPUTE | core running 64 rounds + final add
//   TX_SEND | shifting out the 32 digest bytes
module sha256_top
    import sha256_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic data_in,
    output logic data_out
);

    localparam int            TW       = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

    state_t                    state, state_nxt;
    rx_state_t                 rx_st;
    logic                      rx_s1, rx_s2, rx_s3;
    logic [TW-1:0]             rx_tmr;
    logic [2:0]                rx_bit;
    logic [7:0]                rx_sh;
    logic                      rx_valid;
    logic [5:0]                byte_cnt;
    logic [16*DATA_WIDTH-1:0]  blk;
    logic                      core_start;
    logic                      core_done;
    logic [255:0]              core_digest;
    logic [TW-1:0]             tx_tmr;
    logic [3:0]                tx_bit;
    logic [4:0]                tx_byte;
    logic [8:0]                tx_frame;
    logic [255:0]              tx_dig;
    logic                      byte_accept;
    logic                      tx_end;

    assign byte_accept = (state == RX_WAIT) && rx_valid;
    assign tx_end      = (state == TX_SEND) && (tx_tmr == '0) && (tx_bit == 4'd9) && (tx_byte == 5'd31);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RX_WAIT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RX_WAIT: if (byte_accept && byte_cnt == 6'd63) state_nxt = COMPUTE;
            COMPUTE: if (core_done) state_nxt = TX_SEND;
            TX_SEND: if (tx_end) state_nxt = RX_WAIT;
            default: state_nxt = RX_WAIT;
        endcase
    end

    // Receiver keeps running in every state; its bytes are simply ignored outside RX_WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_s3    <= 1'b1;
            rx_st    <= RX_IDLE;
            rx_tmr   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_s1    <= data_in;
            rx_s2    <= rx_s1;
            rx_s3    <= rx_s2;
            rx_valid <= 1'b0;
            case (rx_st)
                RX_IDLE: if (rx_s3 && !rx_s2) begin
                    rx_st  <= RX_START;
                    rx_tmr <= HALF_LAST;
                end
                RX_START: if (rx_tmr != '0) rx_tmr <= rx_tmr - 1'b1;
                    else if (rx_s2) rx_st <= RX_IDLE;
                    else begin
                        rx_st  <= RX_DATA;
                        rx_tmr <= BIT_LAST;
                        rx_bit <= '0;
                    end
                RX_DATA: if (rx_tmr != '0) rx_tmr <= rx_tmr - 1'b1;
                    else begin
                        rx_sh  <= {rx_s2, rx_sh[7:1]};
                        rx_tmr <= BIT_LAST;
                        rx_bit <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_st <= RX_STOP;
                    end
                RX_STOP: if (rx_tmr != '0) rx_tmr <= rx_tmr - 1'b1;
                    else if (rx_s2) begin
                        rx_valid <= 1'b1;
                        rx_st    <= RX_IDLE;
                    end else rx_st <= RX_HOLD;
                RX_HOLD: if (rx_s2) rx_st <= RX_IDLE;
                default: rx_st <= RX_IDLE;
            endcase
        end
    end

    // Bytes shift in from the bottom, so after 64 accepts byte 0 sits in the top bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt   <= '0;
            blk        <= '0;
            core_start <= 1'b0;
        end else begin
            core_start <= 1'b0;
            if (tx_end) begin
                byte_cnt <= '0;
            end else if (byte_accept) begin
                blk        <= {blk[16*DATA_WIDTH-9:0], rx_sh};
                byte_cnt   <= byte_cnt + 6'd1;
                core_start <= (byte_cnt == 6'd63);
            end
        end
    end

    sha256_core u_core (
        .clk    (clk),
        .rst    (rst),
        .start  (core_start),
        .block  (blk),
        .done   (core_done),
        .digest (core_digest)
    );

    // tx_frame holds {stop, data}; the start bit is driven directly when a byte is loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= 1'b1;
            tx_tmr   <= '0;
            tx_bit   <= '0;
            tx_byte  <= '0;
            tx_frame <= '1;
            tx_dig   <= '0;
        end else if (state == COMPUTE && core_done) begin
            data_out <= 1'b0;
            tx_frame <= {1'b1, core_digest[255:248]};
            tx_dig   <= {core_digest[247:0], 8'h00};
            tx_tmr   <= BIT_LAST;
            tx_bit   <= '0;
            tx_byte  <= '0;
        end else if (state == TX_SEND) begin
            if (tx_tmr != '0) begin
                tx_tmr <= tx_tmr - 1'b1;
            end else begin
                tx_tmr <= BIT_LAST;
                if (tx_bit != 4'd9) begin
                    data_out <= tx_frame[0];
                    tx_frame <= {1'b1, tx_frame[8:1]};
                    tx_bit   <= tx_bit + 4'd1;
                end else if (tx_byte != 5'd31) begin
                    data_out <= 1'b0;
                    tx_frame <= {1'b1, tx_dig[255:248]};
                    tx_dig   <= {tx_dig[247:0], 8'h00};
                    tx_bit   <= '0;
                    tx_byte  <= tx_byte + 5'd1;
                end else begin
                    data_out <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sha256_top.sv
// Scoreboarded bench: stimulus pushes expected digest bytes, a UART monitor on data_out pops and compares.
module tb_sha256_top;

    localparam int CPB  = 8;
    localparam int HALF = CPB / 2;

    localparam logic [255:0] D_SHA   = 256'h5f806d261a579f2eeea477396394699ac2deaf342ec8da3b189d842725a4a697;
    localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    localparam logic [31:0] H0 [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                       32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [31:0] KR [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic data_in = 1'b1;
    logic data_out;

    sha256_top #(.DATA_WIDTH(32), .CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_checks = 0;
    int         n_pass = 0;
    int         t_stop = 0;
    int         t_fall = 0;
    int         rx_count = 0;
    logic [7:0] exp_q[$];
    logic [7:0] blk [64];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook SHA-256 compression of one block: full 64-word schedule, then 64 rounds.
    function automatic logic [255:0] ref_sha(input logic [7:0] m [64]);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, s0, s1, t1, t2;
        for (int t = 0; t < 16; t++) w[t] = {m[4*t], m[4*t+1], m[4*t+2], m[4*t+3]};
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        a = H0[0]; b = H0[1]; c = H0[2]; d = H0[3];
        e = H0[4]; f = H0[5]; g = H0[6]; h = H0[7];
        for (int t = 0; t < 64; t++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + KR[t] + w[t];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {H0[0] + a, H0[1] + b, H0[2] + c, H0[3] + d, H0[4] + e, H0[5] + f, H0[6] + g, H0[7] + h};
    endfunction

    task automatic push_exp(input logic [255:0] dg);
        logic [255:0] tmp;
        tmp = dg;
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(tmp[255:248]);
            tmp = tmp << 8;
        end
    endtask

    task automatic clear_blk();
        for (int i = 0; i < 64; i++) blk[i] = 8'h00;
    endtask

    task automatic load_abc();
        clear_blk();
        blk[0] = 8'h61; blk[1] = 8'h62; blk[2] = 8'h63; blk[3] = 8'h80; blk[63] = 8'h18;
    endtask

    task automatic load_empty();
        clear_blk();
        blk[0] = 8'h80;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        @(negedge clk) data_in = 1'b0;
        repeat (CPB - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk) data_in = b[i];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk) data_in = stop_ok;
        t_stop = cyc;
        repeat (CPB - 1) @(negedge clk);
        @(negedge clk) data_in = 1'b1;
    endtask

    task automatic send_range(input int lo, input int hi, input bit gaps);
        for (int n = lo; n <= hi; n++) begin
            send_byte(blk[n], 1'b1);
            if (gaps) repeat ($urandom_range(0, 2) * CPB) @(negedge clk);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400 * CPB) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else begin
            $display("FAIL %s_timeout: %0d digest bytes outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic check_latency(input string name);
        int lat;
        lat = t_fall - t_stop;
        n_checks++;
        if (lat >= 64 && lat <= 80 + HALF + 4) n_pass++;
        else $display("FAIL %s_latency: got %0d clocks, expected 64..%0d", name, lat, 80 + HALF + 4);
    endtask

    initial begin : monitor
        logic [7:0] b;
        logic [7:0] e;
        logic       prev;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev === 1'b1 && data_out === 1'b0 && !rst) begin
                if (rx_count % 32 == 0) t_fall = cyc;
                repeat (HALF) @(negedge clk);
                check("tx_start_bit", 256'(data_out), 256'(1'b0));
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = data_out;
                end
                repeat (CPB) @(negedge clk);
                check("tx_stop_bit", 256'(data_out), 256'(1'b1));
                rx_count++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_byte: got %02h expected none", b);
                end else begin
                    e = exp_q.pop_front();
                    check("digest_byte", 256'(b), 256'(e));
                end
            end
            prev = data_out;
        end
    end

    initial begin : stimulus
        string s;
        rst = 1'b1;
        data_in = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_data_out", 256'(data_out), 256'(1'b1));
        rst = 1'b0;
        repeat (3 * CPB) @(negedge clk);

        s = "Secure Hash Algorithm 256";
        clear_blk();
        for (int i = 0; i < s.len(); i++) blk[i] = s[i];
        blk[25] = 8'h80;
        blk[63] = 8'hC8;
        push_exp(D_SHA);
        send_range(0, 63, 1'b0);
        wait_drain("sha_string");
        check_latency("sha_string");

        load_abc();
        push_exp(D_ABC);
        send_range(0, 63, 1'b0);
        wait_drain("abc");

        load_empty();
        push_exp(D_EMPTY);
        send_range(0, 63, 1'b0);
        wait_drain("empty_no_chain");

        load_abc();
        push_exp(D_ABC);
        send_range(0, 19, 1'b0);
        send_byte(8'h55, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        send_range(20, 63, 1'b0);
        wait_drain("bad_stop");

        for (int i = 0; i < 64; i++) blk[i] = 8'($urandom);
        send_range(0, 29, 1'b0);
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_reset_data_out", 256'(data_out), 256'(1'b1));
        end
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        load_abc();
        push_exp(D_ABC);
        send_range(0, 63, 1'b0);
        wait_drain("after_reset");

        load_empty();
        push_exp(D_EMPTY);
        send_range(0, 4, 1'b0);
        @(negedge clk) data_in = 1'b0;
        repeat (2) @(negedge clk);
        data_in = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        send_range(5, 63, 1'b0);
        wait_drain("glitch");

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 64; i++) blk[i] = 8'($urandom);
            push_exp(ref_sha(blk));
            send_range(0, 63, 1'b1);
            wait_drain("random_block");
            check_latency("random_block");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sha256_top.md
Name: sha256_top

Overview:
- Standalone UART-attached SHA-256 accelerator.
- Receives one pre-padded 512-bit message block as 64 UART bytes on `data_in` and compresses it from the standard SHA-256 initial hash value.
- Returns the 256-bit digest as 32 UART bytes on `data_out`.
- Top-level FPGA block: a host PC talks to it over a serial link at 115200 baud from a 100 MHz clock.

Parameters:
- DATA_WIDTH, 32, SHA-256 word width; fixed at 32, other values unsupported.
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  1  UART RX line, idle high, 8N1, LSB first.
- data_out  output  1  UART TX line, idle high, 8N1, LSB first.

Behaviour:
- Reset: `data_out`=1, byte counter=0, FSM=RX_WAIT, buffers cleared. Reset mid-operation aborts any RX, compute or TX immediately; `data_out` returns high within the same clock.
- UART RX:
  - `data_in` passes through a 2-flop synchronizer.
  - A falling edge starts a frame. Re-check low at CLKS_PER_BIT/2; if high, it is a false start and the receiver returns to idle.
  - Data bits are sampled every CLKS_PER_BIT after that, LSB first.
  - Stop bit sampled high: byte accepted. Stop bit sampled low: framing error, byte discarded, counter unchanged, receiver waits for the line to return high.
  - Any idle time between frames is accepted.
- Block assembly:
  - Accepted byte n (0..63) is stored as message byte n, big-endian within words: W[0] = {b0,b1,b2,b3}.
  - The host supplies padding and length; the block performs no padding.
- FSM: RX_WAIT -> COMPUTE -> TX_SEND -> RX_WAIT.
  - RX_WAIT → COMPUTE when byte 63 is accepted.
  - COMPUTE → TX_SEND after the final addition.
  - TX_SEND → RX_WAIT after the stop bit of digest byte 31; the byte counter is cleared.
  - RX frames completed outside RX_WAIT are discarded.
- COMPUTE:
  - Load a..h from IV 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
  - 64 rounds, one per clock. W[t] for t≥16 comes from a 16-word rolling schedule: σ0, σ1, mod 2^32.
  - Final cycle: H[i] = IV[i] + working var, mod 2^32.
  - Every block is independent; there is no chaining across blocks.
  - Latency from byte-63 acceptance to the falling edge of the first TX start bit: ≤ 80 clocks.
- UART TX:
  - Per byte: 1 start bit, 8 data bits LSB first, 1 stop bit, each CLKS_PER_BIT clocks.
  - Next byte starts immediately after the stop bit.
  - Byte order is H0[31:24] first through H7[7:0] last (standard hex digest order).
- `data_out` is registered and glitch-free.

Decomposition:
- Package `sha256_pkg`:
  - K[0:63] round-constant array and IV[0:7].
  - Functions Σ0, Σ1, σ0, σ1, Ch, Maj.
  - FSM state enum.
- One sub-module `sha256_core`: `start`, 512-bit block in, `done` pulse, 256-bit digest out; 64-cycle iterative round logic.
- UART RX/TX counters and the FSM stay in the top.

Test Plan:
- Reset asserted, then released; send "Secure Hash Algorithm 256" (25 bytes) + 0x80 + zeros + byte63=0xC8 → 32 bytes received: 5f806d261a579f2eeea4773963946 99ac2deaf342ec8da3b189d842725a4a697 (5f 80 6d 26 … a4 a6 97).
- "abc" block (61 62 63 80 00… byte63=0x18) → ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- Empty message (byte0=0x80, rest 0) sent back-to-back after the previous test, with no reset → e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855, confirming no chaining.
- Frame with stop bit held low inserted mid-block, followed by the full 64 valid bytes → the bad frame is ignored and the digest matches the "abc" digest.
- Reset pulsed after 30 bytes, then the full 64-byte "abc" block sent → `data_out` stays high during the reset; the digest is correct, with no stale bytes.
- Glitch on `data_in` shorter than CLKS_PER_BIT/2 → no byte accepted, counter unchanged.
